// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready holding register.
// Optional framing-error detection is enabled by defining UART_RX_FRAMING_ERR_EN.
module uart_rx_fsm #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       in,
    input  logic       rxReady,
    output logic [7:0] letter_out,
    output logic       rxValid,
    output logic       overrun,
    output logic       frameErr,
    output logic [1:0] o_dbg_state
);

    // Handshake: the held byte transfers on any posedge with rxValid=1 and rxReady=1;
    // rxValid stays high and letter_out stays stable until that edge.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam int          LP_HALF    = CLKS_PER_BIT / 2;
    localparam logic [15:0] LP_BIT_M1  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LP_HALF_M1 = 16'((LP_HALF > 0) ? (LP_HALF - 1) : 0);

    state_t      r_state;
    logic        r_prev_in;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [7:0]  r_letter;
    logic        r_valid;
    logic        r_overrun;
`ifdef UART_RX_FRAMING_ERR_EN
    logic        r_frame_err;
`endif

    logic w_in;
    logic w_bit_tick;
    logic w_half_tick;
    logic w_start_edge;
    logic w_accept;
    logic w_free;

    // An idle transmitter floats the line; anything that is not a solid 0 reads as 1.
    assign w_in         = (in === 1'b0) ? 1'b0 : 1'b1;
    assign w_bit_tick   = (r_cnt == LP_BIT_M1);
    assign w_half_tick  = (r_cnt == LP_HALF_M1);
    assign w_start_edge = r_prev_in & ~w_in;
    assign w_accept     = r_valid & rxReady;
    assign w_free       = ~r_valid | rxReady;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_prev_in   <= 1'b0;
            r_cnt       <= 16'd0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_letter    <= 8'h00;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_prev_in <= w_in;
            r_overrun <= 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
            r_frame_err <= 1'b0;
`endif
            if (w_accept) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_cnt <= 16'd0;
                        // With a zero half-bit wait the detecting edge is also the confirming edge.
                        if (LP_HALF == 0) begin
                            r_state <= S_DATA;
                            r_idx   <= 3'd0;
                        end else begin
                            r_state <= S_START;
                        end
                    end
                end

                S_START: begin
                    if (w_half_tick) begin
                        r_cnt <= 16'd0;
                        if (!w_in) begin
                            r_state <= S_DATA;
                            r_idx   <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_DATA: begin
                    if (w_bit_tick) begin
                        r_cnt          <= 16'd0;
                        r_shift[r_idx] <= w_in;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_STOP: begin
                    if (w_bit_tick) begin
                        r_cnt   <= 16'd0;
                        r_state <= S_IDLE;
`ifdef UART_RX_FRAMING_ERR_EN
                        if (!w_in) begin
                            r_frame_err <= 1'b1;
                        end else if (w_free) begin
                            r_letter <= r_shift;
                            r_valid  <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
`else
                        if (w_free) begin
                            r_letter <= r_shift;
                            r_valid  <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign letter_out  = r_letter;
    assign rxValid     = r_valid;
    assign overrun     = r_overrun;
    assign o_dbg_state = r_state;
`ifdef UART_RX_FRAMING_ERR_EN
    assign frameErr    = r_frame_err;
`else
    assign frameErr    = 1'b0;
`endif

endmodule
